// File: rtl/packet_sink.sv
// Receiving end of a two-phase req/ack flit link: reassembles FLITS-flit packets
// (flit MSB marks a head), flags framing errors and stops after PACKETS packets.
module packet_sink #(
  parameter int ID      = 0,
  parameter int FLITS   = 8,
  parameter int SIZE    = 8,
  parameter int PACKETS = 2
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    req_i,
  input  logic [SIZE-1:0]         data_i,
  input  logic                    stall_i,
  output logic                    ack_o,
  output logic                    pkt_valid_o,
  output logic [FLITS*SIZE-1:0]   pkt_data_o,
  output logic [7:0]              packet_count_o,
  output logic                    error_o,
  output logic                    done_o
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_BODY = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [7:0] LAST_IDX   = 8'(FLITS - 1);
  localparam logic [7:0] PKT_TARGET = 8'(PACKETS);

  if (FLITS < 1 || FLITS > 255 || PACKETS < 1 || PACKETS > 255 || SIZE < 1 || ID < 0) begin : g_bad_params
    $error("packet_sink: illegal parameter set");
  end

  logic [1:0]            state_q, state_d;
  logic                  req_old_q, req_old_d;
  logic                  ack_q, ack_d;
  logic [7:0]            cnt_q, cnt_d;
  logic                  pkt_valid_q, pkt_valid_d;
  logic [FLITS*SIZE-1:0] pkt_data_q, pkt_data_d;
  logic [7:0]            pkt_cnt_q, pkt_cnt_d;
  logic                  error_q, error_d;
  logic [FLITS*SIZE-1:0] buf_q;
  logic [FLITS*SIZE-1:0] buf_merged;

  logic                  accept;
  logic                  head;
  logic                  wr_en;
  logic [7:0]            wr_idx;
  logic                  complete;

  // A held toggle stays pending until accepted, so stall never loses a flit.
  assign accept = (req_i ^ req_old_q) && !stall_i && (state_q != S_DONE);
  assign head   = data_i[SIZE-1];

  // Buffer with the current flit already merged, so completion sees the final flit.
  for (genvar gi = 0; gi < FLITS; gi++) begin : g_slot
    assign buf_merged[gi*SIZE +: SIZE] = (wr_en && (wr_idx == 8'(gi))) ? data_i
                                                                       : buf_q[gi*SIZE +: SIZE];
  end

  always_comb begin
    state_d     = state_q;
    req_old_d   = req_old_q;
    ack_d       = ack_q;
    cnt_d       = cnt_q;
    pkt_valid_d = 1'b0;
    pkt_data_d  = pkt_data_q;
    pkt_cnt_d   = pkt_cnt_q;
    error_d     = error_q;
    wr_en       = 1'b0;
    wr_idx      = 8'd0;
    complete    = 1'b0;

    if (accept) begin
      req_old_d = req_i;
      ack_d     = ~ack_q;
      if (head) begin
        // A head inside a packet drops the partial packet and restarts from it.
        if (state_q == S_BODY) error_d = 1'b1;
        wr_en    = 1'b1;
        wr_idx   = 8'd0;
        cnt_d    = 8'd1;
        state_d  = S_BODY;
        complete = (LAST_IDX == 8'd0);
      end else if (state_q == S_BODY) begin
        wr_en    = 1'b1;
        wr_idx   = cnt_q;
        cnt_d    = cnt_q + 8'd1;
        complete = (cnt_q == LAST_IDX);
      end else begin
        error_d = 1'b1;
      end

      if (complete) begin
        pkt_valid_d = 1'b1;
        pkt_data_d  = buf_merged;
        pkt_cnt_d   = pkt_cnt_q + 8'd1;
        cnt_d       = 8'd0;
        state_d     = (pkt_cnt_q + 8'd1 == PKT_TARGET) ? S_DONE : S_IDLE;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      req_old_q   <= 1'b0;
      ack_q       <= 1'b0;
      cnt_q       <= 8'd0;
      pkt_valid_q <= 1'b0;
      pkt_data_q  <= '0;
      pkt_cnt_q   <= 8'd0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_old_q   <= req_old_d;
      ack_q       <= ack_d;
      cnt_q       <= cnt_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_data_q  <= pkt_data_d;
      pkt_cnt_q   <= pkt_cnt_d;
      error_q     <= error_d;
    end
  end

  // Reassembly storage needs no reset: every slot is rewritten before it is published.
  always_ff @(posedge clk_i) begin
    if (wr_en) buf_q <= buf_merged;
  end

  assign ack_o          = ack_q;
  assign pkt_valid_o    = pkt_valid_q;
  assign pkt_data_o     = pkt_data_q;
  assign packet_count_o = pkt_cnt_q;
  assign error_o        = error_q;
  assign done_o         = (state_q == S_DONE);

endmodule

// File: tb/tb_packet_sink.sv
// Self-checking bench for packet_sink: randomized flits checked against a queue-based
// packet reassembly model, plus directed stall, framing, reset and done scenarios.
module tb_packet_sink;
  localparam int FLITS   = 8;
  localparam int SIZE    = 8;
  localparam int PACKETS = 2;

  logic                  clk   = 1'b0;
  logic                  rst_n = 1'b0;
  logic                  req   = 1'b0;
  logic                  stall = 1'b0;
  logic [SIZE-1:0]       data  = '0;
  logic                  ack, pkt_valid, error, done;
  logic [FLITS*SIZE-1:0] pkt_data;
  logic [7:0]            packet_count;

  int tests = 0;
  int fails = 0;

  // Reference model state
  bit                    m_in_pkt;
  logic [SIZE-1:0]       m_q[$];
  bit                    m_err;
  int                    m_cnt;
  logic [FLITS*SIZE-1:0] m_pkt;
  bit                    m_valid;

  packet_sink #(.ID(0), .FLITS(FLITS), .SIZE(SIZE), .PACKETS(PACKETS)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_i(req), .data_i(data), .stall_i(stall),
    .ack_o(ack), .pkt_valid_o(pkt_valid), .pkt_data_o(pkt_data),
    .packet_count_o(packet_count), .error_o(error), .done_o(done)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_in_pkt = 0; m_q.delete(); m_err = 0; m_cnt = 0; m_pkt = '0; m_valid = 0;
  endtask

  task automatic model_flit(input logic [SIZE-1:0] d);
    m_valid = 0;
    if (d[SIZE-1]) begin
      if (m_in_pkt) m_err = 1;
      m_q.delete();
      m_q.push_back(d);
      m_in_pkt = 1;
    end else if (!m_in_pkt) begin
      m_err = 1;
    end else begin
      m_q.push_back(d);
    end
    if (m_in_pkt && m_q.size() == FLITS) begin
      for (int i = 0; i < FLITS; i++) m_pkt[i*SIZE +: SIZE] = m_q[i];
      m_cnt++;
      m_valid  = 1;
      m_in_pkt = 0;
      m_q.delete();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; req = 1'b0; stall = 1'b0; data = '0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  // Toggle req with data d, hold stall for stall_cyc cycles, then wait (bounded) for ack.
  task automatic drive_flit(input logic [SIZE-1:0] d, input int stall_cyc,
                            output bit acked, output bit held, output int lat);
    logic ack0;
    @(negedge clk);
    data  = d;
    req   = ~req;
    stall = (stall_cyc > 0);
    ack0  = ack;
    held  = 1;
    for (int i = 0; i < stall_cyc; i++) begin
      @(negedge clk);
      if (ack !== ack0) held = 0;
    end
    stall = 1'b0;
    acked = 0;
    lat   = 0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (ack !== ack0) begin acked = 1; lat = i; break; end
    end
  endtask

  task automatic test_reset();
    #1;
    tests++; if ({ack, pkt_valid, error, done} !== 4'b0)
      begin fails++; $display("FAIL reset_flags got=%b want=0000", {ack, pkt_valid, error, done}); end
    tests++; if (pkt_data !== '0)
      begin fails++; $display("FAIL reset_pkt_data got=%h want=0", pkt_data); end
    tests++; if (packet_count !== 8'd0)
      begin fails++; $display("FAIL reset_count got=%0d want=0", packet_count); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    $display("[TB] test_reset done");
  endtask

  task automatic test_nominal();
    bit acked, held; int lat; logic [SIZE-1:0] d;
    do_reset();
    for (int p = 0; p < PACKETS; p++) begin
      for (int f = 0; f < FLITS; f++) begin
        d = (f == 0) ? (8'h80 | 8'($urandom)) : (8'($urandom) & 8'h7F);
        drive_flit(d, 0, acked, held, lat);
        model_flit(d);
        $display("[TB] nominal flit %02h acked=%0d pkt_valid=%0d count=%0d", d, acked, pkt_valid, packet_count);
        tests++; if (!acked || lat != 1)
          begin fails++; $display("FAIL nominal_ack got acked=%0d lat=%0d want acked=1 lat=1", acked, lat); end
        tests++; if (pkt_valid !== m_valid)
          begin fails++; $display("FAIL nominal_valid got=%b want=%b", pkt_valid, m_valid); end
        if (m_valid) begin
          tests++; if (pkt_data !== m_pkt)
            begin fails++; $display("FAIL nominal_pkt_data got=%h want=%h", pkt_data, m_pkt); end
        end
        tests++; if (packet_count !== 8'(m_cnt))
          begin fails++; $display("FAIL nominal_count got=%0d want=%0d", packet_count, m_cnt); end
        tests++; if (error !== 1'b0)
          begin fails++; $display("FAIL nominal_error got=%b want=0", error); end
        tests++; if (done !== (m_cnt == PACKETS))
          begin fails++; $display("FAIL nominal_done got=%b want=%b", done, (m_cnt == PACKETS)); end
      end
      @(negedge clk);
      tests++; if (pkt_valid !== 1'b0)
        begin fails++; $display("FAIL nominal_pulse_width got=%b want=0", pkt_valid); end
    end
  endtask

  task automatic test_after_done();
    logic ack0; bit changed;
    @(negedge clk);
    data = 8'h80; req = ~req; ack0 = ack; changed = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ack !== ack0) changed = 1;
    end
    $display("[TB] after_done extra toggle ack_changed=%0d done=%0d count=%0d", changed, done, packet_count);
    tests++; if (changed)
      begin fails++; $display("FAIL after_done_ack got=changed want=unchanged"); end
    tests++; if (done !== 1'b1)
      begin fails++; $display("FAIL after_done_done got=%b want=1", done); end
    tests++; if (packet_count !== 8'(PACKETS))
      begin fails++; $display("FAIL after_done_count got=%0d want=%0d", packet_count, PACKETS); end
  endtask

  task automatic test_stall();
    bit acked, held; int lat; logic [SIZE-1:0] d;
    do_reset();
    drive_flit(8'h85, 5, acked, held, lat);
    model_flit(8'h85);
    $display("[TB] stall flit 85 held=%0d acked=%0d lat=%0d", held, acked, lat);
    tests++; if (!held)
      begin fails++; $display("FAIL stall_hold got=ack_toggled want=ack_constant"); end
    tests++; if (!acked || lat != 1)
      begin fails++; $display("FAIL stall_release got acked=%0d lat=%0d want acked=1 lat=1", acked, lat); end
    for (int i = 1; i < FLITS; i++) begin
      d = 8'(i);
      drive_flit(d, 0, acked, held, lat);
      model_flit(d);
    end
    $display("[TB] stall packet pkt_valid=%0d pkt_data=%h", pkt_valid, pkt_data);
    tests++; if (pkt_valid !== 1'b1 || pkt_data[7:0] !== 8'h85)
      begin fails++; $display("FAIL stall_head got valid=%b byte0=%h want valid=1 byte0=85", pkt_valid, pkt_data[7:0]); end
    tests++; if (pkt_data !== m_pkt)
      begin fails++; $display("FAIL stall_pkt_data got=%h want=%h", pkt_data, m_pkt); end
  endtask

  task automatic test_missing_head();
    bit acked, held; int lat; logic [SIZE-1:0] d;
    do_reset();
    drive_flit(8'h05, 0, acked, held, lat);
    model_flit(8'h05);
    $display("[TB] missing_head flit 05 acked=%0d error=%0d", acked, error);
    tests++; if (!acked)
      begin fails++; $display("FAIL missing_head_ack got=no_ack want=ack"); end
    tests++; if (error !== 1'b1 || packet_count !== 8'd0)
      begin fails++; $display("FAIL missing_head_error got err=%b cnt=%0d want err=1 cnt=0", error, packet_count); end
    for (int i = 0; i < FLITS; i++) begin
      d = (i == 0) ? 8'h85 : 8'(i);
      drive_flit(d, 0, acked, held, lat);
      model_flit(d);
    end
    $display("[TB] missing_head packet pkt_valid=%0d pkt_data=%h", pkt_valid, pkt_data);
    tests++; if (pkt_valid !== 1'b1 || pkt_data[7:0] !== 8'h85 || pkt_data !== m_pkt)
      begin fails++; $display("FAIL missing_head_pkt got valid=%b data=%h want valid=1 data=%h", pkt_valid, pkt_data, m_pkt); end
    tests++; if (error !== 1'b1)
      begin fails++; $display("FAIL missing_head_sticky got=%b want=1", error); end
  endtask

  task automatic test_unexpected_head();
    bit acked, held; int lat; logic [SIZE-1:0] d;
    logic [SIZE-1:0] pre [3];
    pre[0] = 8'h80; pre[1] = 8'h11; pre[2] = 8'h22;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive_flit(pre[i], 0, acked, held, lat);
      model_flit(pre[i]);
    end
    tests++; if (error !== 1'b0)
      begin fails++; $display("FAIL unexp_head_early_error got=%b want=0", error); end
    drive_flit(8'h9A, 0, acked, held, lat);
    model_flit(8'h9A);
    $display("[TB] unexp_head flit 9a error=%0d pkt_valid=%0d", error, pkt_valid);
    tests++; if (error !== 1'b1 || pkt_valid !== 1'b0)
      begin fails++; $display("FAIL unexp_head_error got err=%b valid=%b want err=1 valid=0", error, pkt_valid); end
    for (int i = 0; i < FLITS - 1; i++) begin
      d = 8'($urandom) & 8'h7F;
      drive_flit(d, 0, acked, held, lat);
      model_flit(d);
      tests++; if (pkt_valid !== (i == FLITS - 2))
        begin fails++; $display("FAIL unexp_head_valid_at_%0d got=%b want=%b", i, pkt_valid, (i == FLITS - 2)); end
    end
    $display("[TB] unexp_head packet pkt_data=%h", pkt_data);
    tests++; if (pkt_data[7:0] !== 8'h9A || pkt_data !== m_pkt)
      begin fails++; $display("FAIL unexp_head_pkt got=%h want=%h", pkt_data, m_pkt); end
  endtask

  task automatic test_reset_mid();
    bit acked, held; int lat; logic [SIZE-1:0] d;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      d = (i == 0) ? 8'hC3 : 8'(i);
      drive_flit(d, 0, acked, held, lat);
    end
    @(negedge clk);
    #2 rst_n = 1'b0; req = 1'b0;
    #1;
    $display("[TB] reset_mid asserted ack=%0d count=%0d err=%0d", ack, packet_count, error);
    tests++; if ({ack, pkt_valid, error, done} !== 4'b0 || pkt_data !== '0 || packet_count !== 8'd0)
      begin fails++; $display("FAIL reset_mid_async got flags=%b cnt=%0d want all zero", {ack, pkt_valid, error, done}, packet_count); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    model_reset();
    for (int i = 0; i < FLITS; i++) begin
      d = (i == 0) ? 8'h81 : (8'($urandom) & 8'h7F);
      drive_flit(d, 0, acked, held, lat);
      model_flit(d);
    end
    $display("[TB] reset_mid packet valid=%0d count=%0d data=%h", pkt_valid, packet_count, pkt_data);
    tests++; if (pkt_valid !== 1'b1 || packet_count !== 8'd1 || pkt_data !== m_pkt)
      begin fails++; $display("FAIL reset_mid_packet got valid=%b cnt=%0d data=%h want valid=1 cnt=1 data=%h", pkt_valid, packet_count, pkt_data, m_pkt); end
  endtask

  task automatic test_random();
    bit acked, held; int lat; logic [SIZE-1:0] d; int st; int n;
    for (int round = 0; round < 3; round++) begin
      do_reset();
      n = 0;
      while (m_cnt < PACKETS && n < 60) begin
        d = 8'($urandom);
        if ($urandom_range(0, 7) != 0) d[SIZE-1] = !m_in_pkt;
        st = $urandom_range(0, 3);
        drive_flit(d, st, acked, held, lat);
        model_flit(d);
        n++;
        $display("[TB] random r%0d flit %02h stall=%0d acked=%0d valid=%0d cnt=%0d err=%0d", round, d, st, acked, pkt_valid, packet_count, error);
        tests++; if (!held || !acked || lat != 1)
          begin fails++; $display("FAIL random_ack got held=%0d acked=%0d lat=%0d want 1 1 1", held, acked, lat); end
        tests++; if (pkt_valid !== m_valid || packet_count !== 8'(m_cnt) || error !== m_err)
          begin fails++; $display("FAIL random_status got v=%b c=%0d e=%b want v=%b c=%0d e=%b", pkt_valid, packet_count, error, m_valid, m_cnt, m_err); end
        if (m_valid) begin
          tests++; if (pkt_data !== m_pkt)
            begin fails++; $display("FAIL random_pkt_data got=%h want=%h", pkt_data, m_pkt); end
        end
        tests++; if (done !== (m_cnt == PACKETS))
          begin fails++; $display("FAIL random_done got=%b want=%b", done, (m_cnt == PACKETS)); end
      end
      if (m_cnt == PACKETS) begin
        drive_flit(8'h80, 0, acked, held, lat);
        tests++; if (acked)
          begin fails++; $display("FAIL random_post_done_ack got=acked want=no_ack"); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nominal();
    test_after_done();
    test_stall();
    test_missing_head();
    test_unexpected_head();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
